score_keeper: RTL and testbench

//  Match scoreboard for the two-player tank game. Collects single-cycle point

---
 rtl/score_pkg.sv | 18 +
 rtl/frame_timer.sv | 26 ++
 rtl/score_keeper.sv | 148 ++++++++++++++
 tb/tb_score_keeper.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the tank-game scoreboard.
package score_pkg;

    localparam int SCORE_W = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    typedef enum logic [1:0] {PLAY, ROUND_END, GAME_OVER} state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter stepped by frame pulses; holds at zero.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: two-player scoreboard and play/pause/game-over sequencer.
// Optional winner-digit flashing is built when SCORE_FLASH_EN is defined.
module score_keeper
    import score_pkg::*;
#(
    parameter int WIN_SCORE          = 10,
    parameter int ROUND_PAUSE_FRAMES = 120
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_i,
    input  logic               point_p1_i,
    input  logic               point_p2_i,
    input  logic               new_game_i,
    output logic [SCORE_W-1:0] score_player_1_o,
    output logic [SCORE_W-1:0] score_player_2_o,
    output logic               freeze_o,
    output logic               round_over_o,
    output logic [1:0]         winner_o,
    output logic               score_blank_o
);

    localparam int TW = $clog2(ROUND_PAUSE_FRAMES + 1);
    localparam logic [TW-1:0] PAUSE_LD = TW'(ROUND_PAUSE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    if (WIN_SCORE < 1 || WIN_SCORE > 63) begin : g_bad_win
        $fatal(1, "score_keeper: WIN_SCORE must be in 1..63");
    end
    if (ROUND_PAUSE_FRAMES < 1) begin : g_bad_pause
        $fatal(1, "score_keeper: ROUND_PAUSE_FRAMES must be >= 1");
    end

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic               pend1_q, pend1_d, pend2_q, pend2_d;
    logic [1:0]         winner_q, winner_d;
    logic               freeze_q, round_over_q;
    logic               hit1, hit2;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]      tmr_val;

    frame_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Point pulses landing on the frame cycle itself still count this frame.
    assign hit1 = pend1_q | point_p1_i;
    assign hit2 = pend2_q | point_p2_i;

    always_comb begin
        state_d  = state_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        pend1_d  = pend1_q;
        pend2_d  = pend2_q;
        winner_d = winner_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = PAUSE_LD;
        if (new_game_i) begin
            state_d  = PLAY;
            s1_d     = '0;
            s2_d     = '0;
            pend1_d  = 1'b0;
            pend2_d  = 1'b0;
            winner_d = WINNER_NONE;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end else if (state_q == PLAY) begin
            pend1_d = frame_i ? 1'b0 : hit1;
            pend2_d = frame_i ? 1'b0 : hit2;
            if (frame_i && (hit1 || hit2)) begin
                s1_d = hit1 ? sat_inc(s1_q) : s1_q;
                s2_d = hit2 ? sat_inc(s2_q) : s2_q;
                if (s1_d >= WIN || s2_d >= WIN) begin
                    state_d  = GAME_OVER;
                    winner_d = {s2_d >= WIN, s1_d >= WIN};
                end else begin
                    state_d  = ROUND_END;
                    tmr_load = 1'b1;
                end
            end
        end else if (state_q == ROUND_END && frame_i) begin
            state_d = tmr_zero ? PLAY : ROUND_END;
            tmr_dec = !tmr_zero;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= PLAY;
            s1_q         <= '0;
            s2_q         <= '0;
            pend1_q      <= 1'b0;
            pend2_q      <= 1'b0;
            winner_q     <= WINNER_NONE;
            freeze_q     <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            winner_q     <= winner_d;
            freeze_q     <= (state_d != PLAY);
            round_over_q <= (state_d == ROUND_END);
        end
    end

`ifdef SCORE_FLASH_EN
    logic [3:0] flash_cnt_q;
    logic       blank_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flash_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (new_game_i) begin
            flash_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (state_q != GAME_OVER && state_d == GAME_OVER) begin
            flash_cnt_q <= '0;
            blank_q     <= 1'b1;
        end else if (state_q == GAME_OVER && frame_i) begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
            blank_q     <= (flash_cnt_q == 4'hF) ? ~blank_q : blank_q;
        end
    end

    assign score_blank_o = blank_q;
`else
    assign score_blank_o = 1'b0;
`endif

    assign score_player_1_o = s1_q;
    assign score_player_2_o = s2_q;
    assign freeze_o         = freeze_q;
    assign round_over_o     = round_over_q;
    assign winner_o         = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed and random checks of score_keeper against a behavioural model.
module tb_score_keeper;

    localparam int WIN   = 10;
    localparam int PAUSE = 3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       frame_i = 1'b0, point_p1_i = 1'b0, point_p2_i = 1'b0, new_game_i = 1'b0;
    logic [5:0] score_player_1_o, score_player_2_o;
    logic       freeze_o, round_over_o, score_blank_o;
    logic [1:0] winner_o;

    int total = 0;
    int bad = 0;

    // behavioural model: mode 0=play 1=pause 2=over
    int   m_s1, m_s2, m_mode, m_left, m_fcnt;
    bit   m_p1, m_p2, m_blank;
    logic [1:0] m_win;

    score_keeper #(.WIN_SCORE(WIN), .ROUND_PAUSE_FRAMES(PAUSE)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .frame_i          (frame_i),
        .point_p1_i       (point_p1_i),
        .point_p2_i       (point_p2_i),
        .new_game_i       (new_game_i),
        .score_player_1_o (score_player_1_o),
        .score_player_2_o (score_player_2_o),
        .freeze_o         (freeze_o),
        .round_over_o     (round_over_o),
        .winner_o         (winner_o),
        .score_blank_o    (score_blank_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_left = 0; m_fcnt = 0;
        m_p1 = 0; m_p2 = 0; m_blank = 0; m_win = 2'b00;
    endtask

    task automatic m_update(input bit f, input bit p1, input bit p2, input bit ng);
        bit h1, h2;
        if (ng) begin
            m_reset();
            return;
        end
        if (m_mode == 0) begin
            h1 = m_p1 | p1;
            h2 = m_p2 | p2;
            m_p1 = f ? 0 : h1;
            m_p2 = f ? 0 : h2;
            if (f && (h1 || h2)) begin
                if (h1) m_s1 = (m_s1 < 63) ? m_s1 + 1 : 63;
                if (h2) m_s2 = (m_s2 < 63) ? m_s2 + 1 : 63;
                if (m_s1 >= WIN || m_s2 >= WIN) begin
                    m_mode = 2;
                    m_win = {m_s2 >= WIN, m_s1 >= WIN};
                    m_fcnt = 0;
                    m_blank = 1;
                end else begin
                    m_mode = 1;
                    m_left = PAUSE;
                end
            end
        end else if (m_mode == 1) begin
            if (f) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end else if (f) begin
            m_fcnt++;
            if (m_fcnt % 16 == 0) m_blank = !m_blank;
        end
    endtask

    task automatic check_all();
        chk("score1", {2'b0, score_player_1_o}, 8'(m_s1));
        chk("score2", {2'b0, score_player_2_o}, 8'(m_s2));
        chk("freeze", {7'b0, freeze_o}, {7'b0, m_mode != 0});
        chk("round_over", {7'b0, round_over_o}, {7'b0, m_mode == 1});
        chk("winner", {6'b0, winner_o}, {6'b0, m_win});
`ifdef SCORE_FLASH_EN
        chk("blank", {7'b0, score_blank_o}, {7'b0, m_blank});
`else
        chk("blank", {7'b0, score_blank_o}, 8'd0);
`endif
    endtask

    task automatic step(input bit f, input bit p1, input bit p2, input bit ng);
        @(negedge clk_i);
        frame_i = f; point_p1_i = p1; point_p2_i = p2; new_game_i = ng;
        @(posedge clk_i);
        m_update(f, p1, p2, ng);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        m_reset();
        #12;
        check_all();
        @(negedge clk_i);
        rst_i = 1'b0;

        // single point then frame five cycles later
        step(0, 1, 0, 0);
        idle(4);
        step(1, 0, 0, 0);
        chk("t1_score1", {2'b0, score_player_1_o}, 8'd1);
        chk("t1_freeze", {7'b0, freeze_o}, 8'd1);
        chk("t1_round_over", {7'b0, round_over_o}, 8'd1);

        // pause lasts exactly PAUSE frames and ignores points
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("t2_still_paused", {7'b0, freeze_o}, 8'd1);
        step(1, 0, 0, 0);
        chk("t2_play", {7'b0, freeze_o}, 8'd0);
        chk("t2_p2_zero", {2'b0, score_player_2_o}, 8'd0);

        // repeated pulses within one frame count once
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("t4_p2_once", {2'b0, score_player_2_o}, 8'd1);
        for (int i = 0; i < PAUSE; i++) step(1, 0, 0, 0);

        // reset in the middle of a pause
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b0;

        // both players to 9, then a simultaneous point: draw
        for (int r = 0; r < WIN - 1; r++) begin
            step(1, 1, 1, 0);
            for (int i = 0; i < PAUSE; i++) step(1, 0, 0, 0);
        end
        chk("t3_pre1", {2'b0, score_player_1_o}, 8'd9);
        step(0, 1, 0, 0);
        step(1, 0, 1, 0);
        chk("t3_s1", {2'b0, score_player_1_o}, 8'd10);
        chk("t3_s2", {2'b0, score_player_2_o}, 8'd10);
        chk("t3_winner", {6'b0, winner_o}, 8'd3);
        for (int i = 0; i < 40; i++) step(1, i[0], 1, 0);
        chk("t3_winner_held", {6'b0, winner_o}, 8'd3);

        // new game beats frame and point in the same cycle
        step(1, 1, 0, 1);
        chk("t5_s1", {2'b0, score_player_1_o}, 8'd0);
        chk("t5_s2", {2'b0, score_player_2_o}, 8'd0);
        chk("t5_winner", {6'b0, winner_o}, 8'd0);
        chk("t5_freeze", {7'b0, freeze_o}, 8'd0);

        // P1 wins outright, then watch flashing for 48 frames
        for (int r = 0; r < WIN - 1; r++) begin
            step(1, 1, 0, 0);
            for (int i = 0; i < PAUSE; i++) step(1, 0, 0, 0);
        end
        step(1, 1, 0, 0);
        chk("t6_winner", {6'b0, winner_o}, 8'd1);
        for (int i = 0; i < 48; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
